// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcode map, requester ids,
// and the response-slot state type.
package alu_pkg;

  // ALUOp width; must track the datapath ALU decoder.
  localparam int ALU_OP_W = 4;

  // Arithmetic / logic opcodes.
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;

  // Branch-compare opcodes; they produce 0/1 in bit 0.
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_BLT  = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_BGE  = 4'd12;
  localparam logic [ALU_OP_W-1:0] ALU_BLTU = 4'd13;
  localparam logic [ALU_OP_W-1:0] ALU_BGEU = 4'd14;

  // Requester ids as carried on rsp_id.
  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_BR   = 1'b1;

  // Response slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The pointer names the
// port that wins a tie; the caller owns and updates the pointer.
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       onehot0
);

  // Lone requester always wins; on a tie the pointer decides.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt[ptr] = 1'b1;
      end else begin
        gnt[REQ_EXEC] = req[REQ_EXEC];
        gnt[REQ_BR]   = req[REQ_BR];
      end
    end
  end

  // Sanity flag: at most one grant bit is set.
  always_comb begin
    onehot0 = ~(gnt[REQ_EXEC] & gnt[REQ_BR]);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the
// branch-compare unit (port 1). The winner's operands feed the ALU in the
// grant cycle; the result lands in a single registered response slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_srca,
  input  logic [WIDTH-1:0]    req0_srcb,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_srca,
  input  logic [WIDTH-1:0]    req1_srcb,
  input  logic [ALU_OP_W-1:0] req1_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic                rsp_zero,
  output logic                rsp_id
);

  localparam int SH_W = $clog2(WIDTH);

  slot_state_t         state;
  slot_state_t         state_next;
  logic                rr_ptr;
  logic                can_issue;
  logic                arb_en;
  logic [1:0]          gnt;
  logic                gnt_onehot0;
  logic                grant;
  logic                winner;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [SH_W-1:0]     shamt;
  logic [WIDTH-1:0]    alu_result;

  rr_arb2 u_arb (
    .req     ({req1_valid, req0_valid}),
    .en      (arb_en),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .onehot0 (gnt_onehot0)
  );

  // A grant is only honoured when the arbiter produced a single winner.
  assign grant  = (gnt[REQ_EXEC] | gnt[REQ_BR]) & gnt_onehot0;
  assign winner = gnt[REQ_BR];

  // Route the winning requester's operation into the shared ALU.
  always_comb begin
    alu_a  = gnt[REQ_BR] ? req1_srca : req0_srca;
    alu_b  = gnt[REQ_BR] ? req1_srcb : req0_srcb;
    alu_op = gnt[REQ_BR] ? req1_op   : req0_op;
    shamt  = alu_b[SH_W-1:0];
  end

  // Datapath ALU; compare results are zero-extended single bits.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $signed(alu_a) >>> shamt;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_EQ:   alu_result = {{(WIDTH-1){1'b0}}, alu_a == alu_b};
      ALU_BLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_BGE:  alu_result = {{(WIDTH-1){1'b0}}, $signed(alu_a) >= $signed(alu_b)};
      ALU_BLTU: alu_result = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      ALU_BGEU: alu_result = {{(WIDTH-1){1'b0}}, alu_a >= alu_b};
      default:  alu_result = '0;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Slot next-state: fill on grant, drain when consumed with no refill.
  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (grant) state_next = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !grant) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  // Slot outputs: issue allowed when empty or being drained this cycle.
  // Gating with rst_n keeps both readies low while reset is held.
  always_comb begin
    rsp_valid  = (state == SLOT_FULL);
    can_issue  = (state == SLOT_EMPTY) | rsp_ready;
    arb_en     = can_issue & rst_n;
    req0_ready = gnt[REQ_EXEC];
    req1_ready = gnt[REQ_BR];
  end

  // Round-robin pointer points away from the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= REQ_EXEC;
    end else if (grant) begin
      rr_ptr <= ~winner;
    end
  end

  // Capture result, zero flag and id on grant; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (grant) begin
      rsp_result <= alu_result;
      rsp_zero   <= (alu_result == '0);
      rsp_id     <= winner;
    end
  end

endmodule
